// File: rtl/lv1a_trig_sched.sv
// Trigger scheduler in front of the lv1a pipeline.
// Per-source mask and prescale, a hold-off gate, lv1b credit limiting, and a run-control FSM.
// The FSM keeps the pipeline free of triggers while it arms and drains.
module lv1a_trig_sched #(
    parameter int unsigned HOLDOFF = 20,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ARM_DLY = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_live,
    input  logic [15:0]  in_int_req,
    input  logic [3:0]   in_ext_req,
    input  logic         in_delta_req,
    input  logic [15:0]  int_mask,
    input  logic [3:0]   ext_mask,
    input  logic         delta_ena,
    input  logic [127:0] int_prescale,
    input  logic [31:0]  ext_prescale,
    input  logic         in_lv1b_done,
    output logic [15:0]  out_int_lv1a,
    output logic [3:0]   out_ext_lv1a,
    output logic         out_delta_lv1a,
    output logic         out_busy,
    output logic [4:0]   outstanding,
    output logic [31:0]  acc_cnt,
    output logic [31:0]  rej_cnt,
    output logic         credit_err
);

    localparam int unsigned HW = $clog2(HOLDOFF + 1);
    localparam int unsigned AW = $clog2(ARM_DLY + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
    localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_DLY - 1);
    localparam logic [4:0]    DEPTH_V   = 5'(DEPTH);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic            live_q;
    logic [AW-1:0]   arm_cnt_q, arm_cnt_d;
    logic [HW-1:0]   holdoff_q, holdoff_d;
    logic [7:0]      int_psc_q [16];
    logic [7:0]      int_psc_d [16];
    logic [7:0]      ext_psc_q [4];
    logic [7:0]      ext_psc_d [4];
    logic [15:0]     int_pass;
    logic [3:0]      ext_pass;
    logic            delta_pass;
    logic [4:0]      outst_q, outst_d;
    logic [31:0]     acc_q, acc_d, rej_q, rej_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [15:0]     out_int_q;
    logic [3:0]      out_ext_q;
    logic            out_delta_q;
    logic            arm_entry, qualified, credit_ok, accept, reject, credit_ret;

    // Run-control FSM next state and arm delay counter.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (in_live && !live_q) state_d = StArm;
            end
            StArm: begin
                arm_cnt_d = arm_cnt_q + 1'b1;
                if (!in_live) begin
                    state_d = StIdle;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!in_live) state_d = StDrain;
            end
            StDrain: begin
                // Live can only be high here if it rose during the drain.
                if (outst_q == 5'd0) state_d = in_live ? StArm : StIdle;
            end
            default: state_d = StIdle;
        endcase
        arm_entry = (state_d == StArm) && (state_q != StArm);
    end

    // Per-source prescale qualify; counters only move on masked requests in RUN.
    always_comb begin
        int_pass  = '0;
        ext_pass  = '0;
        int_psc_d = int_psc_q;
        ext_psc_d = ext_psc_q;
        for (int i = 0; i < 16; i++) begin
            if (state_q == StIdle) begin
                int_psc_d[i] = '0;
            end else if (state_q == StRun && in_int_req[i] && int_mask[i] &&
                         int_prescale[8*i +: 8] != 8'd0) begin
                if (int_psc_q[i] == int_prescale[8*i +: 8] - 8'd1) begin
                    int_pass[i]  = 1'b1;
                    int_psc_d[i] = '0;
                end else begin
                    int_psc_d[i] = int_psc_q[i] + 8'd1;
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            if (state_q == StIdle) begin
                ext_psc_d[j] = '0;
            end else if (state_q == StRun && in_ext_req[j] && ext_mask[j] &&
                         ext_prescale[8*j +: 8] != 8'd0) begin
                if (ext_psc_q[j] == ext_prescale[8*j +: 8] - 8'd1) begin
                    ext_pass[j]  = 1'b1;
                    ext_psc_d[j] = '0;
                end else begin
                    ext_psc_d[j] = ext_psc_q[j] + 8'd1;
                end
            end
        end
        delta_pass = (state_q == StRun) && in_delta_req && delta_ena;
    end

    // Accept/reject decision, credits, hold-off and statistics.
    always_comb begin
        qualified  = (|int_pass) || (|ext_pass) || delta_pass;
        credit_ret = in_lv1b_done && (outst_q != 5'd0);
        // A credit returned this cycle frees a slot for a same-cycle accept.
        credit_ok  = (outst_q < DEPTH_V) || credit_ret;
        accept     = qualified && (state_q == StRun) && (holdoff_q == '0) && credit_ok;
        reject     = qualified && !accept;

        outst_d = outst_q;
        if (accept && !credit_ret) begin
            outst_d = outst_q + 5'd1;
        end else if (!accept && credit_ret) begin
            outst_d = outst_q - 5'd1;
        end

        holdoff_d = '0;
        if (accept) begin
            holdoff_d = HOLD_LOAD;
        end else if (holdoff_q != '0 && state_q != StIdle) begin
            holdoff_d = holdoff_q - 1'b1;
        end

        acc_d = acc_q;
        rej_d = rej_q;
        err_d = err_q;
        if (arm_entry) begin
            acc_d = '0;
            rej_d = '0;
            err_d = 1'b0;
        end else begin
            if (accept && acc_q != '1) acc_d = acc_q + 32'd1;
            if (reject && rej_q != '1) rej_d = rej_q + 32'd1;
            if (in_lv1b_done && outst_q == 5'd0) err_d = 1'b1;
        end

        busy_d = (state_d != StRun) || (holdoff_d != '0) || (outst_d >= DEPTH_V);
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            live_q      <= 1'b0;
            arm_cnt_q   <= '0;
            holdoff_q   <= '0;
            for (int i = 0; i < 16; i++) int_psc_q[i] <= '0;
            for (int j = 0; j < 4; j++) ext_psc_q[j] <= '0;
            outst_q     <= '0;
            acc_q       <= '0;
            rej_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_int_q   <= '0;
            out_ext_q   <= '0;
            out_delta_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            live_q      <= in_live;
            arm_cnt_q   <= arm_cnt_d;
            holdoff_q   <= holdoff_d;
            int_psc_q   <= int_psc_d;
            ext_psc_q   <= ext_psc_d;
            outst_q     <= outst_d;
            acc_q       <= acc_d;
            rej_q       <= rej_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            out_int_q   <= accept ? int_pass : 16'd0;
            out_ext_q   <= accept ? ext_pass : 4'd0;
            out_delta_q <= accept && delta_pass;
        end
    end

    assign out_int_lv1a   = out_int_q;
    assign out_ext_lv1a   = out_ext_q;
    assign out_delta_lv1a = out_delta_q;
    assign out_busy       = busy_q;
    assign outstanding    = outst_q;
    assign acc_cnt        = acc_q;
    assign rej_cnt        = rej_q;
    assign credit_err     = err_q;

endmodule

// File: tb/tb_lv1a_trig_sched.sv
// Directed bench for lv1a_trig_sched: arming, prescale, hold-off, credits, drain, re-arm.
module tb_lv1a_trig_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_live;
    logic [15:0]  in_int_req;
    logic [3:0]   in_ext_req;
    logic         in_delta_req;
    logic [15:0]  int_mask;
    logic [3:0]   ext_mask;
    logic         delta_ena;
    logic [127:0] int_prescale;
    logic [31:0]  ext_prescale;
    logic         in_lv1b_done;
    logic [15:0]  out_int_lv1a;
    logic [3:0]   out_ext_lv1a;
    logic         out_delta_lv1a;
    logic         out_busy;
    logic [4:0]   outstanding;
    logic [31:0]  acc_cnt;
    logic [31:0]  rej_cnt;
    logic         credit_err;

    int errors = 0;
    int checks = 0;
    int busy_cnt;
    int exp_acc;
    int exp_rej;
    int exp_out;

    always #5 clk = ~clk;

    lv1a_trig_sched dut (
        .clk           (clk),
        .rst           (rst),
        .in_live       (in_live),
        .in_int_req    (in_int_req),
        .in_ext_req    (in_ext_req),
        .in_delta_req  (in_delta_req),
        .int_mask      (int_mask),
        .ext_mask      (ext_mask),
        .delta_ena     (delta_ena),
        .int_prescale  (int_prescale),
        .ext_prescale  (ext_prescale),
        .in_lv1b_done  (in_lv1b_done),
        .out_int_lv1a  (out_int_lv1a),
        .out_ext_lv1a  (out_ext_lv1a),
        .out_delta_lv1a(out_delta_lv1a),
        .out_busy      (out_busy),
        .outstanding   (outstanding),
        .acc_cnt       (acc_cnt),
        .rej_cnt       (rej_cnt),
        .credit_err    (credit_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One cycle of requests/done, then back to quiet inputs.
    task automatic req(input logic [15:0] iv, input logic [3:0] ev, input logic dv,
                       input logic done);
        in_int_req   = iv;
        in_ext_req   = ev;
        in_delta_req = dv;
        in_lv1b_done = done;
        tick();
        in_int_req   = '0;
        in_ext_req   = '0;
        in_delta_req = 1'b0;
        in_lv1b_done = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic [15:0] ei, input logic [3:0] ee,
                               input logic ed);
        check_eq(tag, {11'd0, out_delta_lv1a, out_ext_lv1a, out_int_lv1a}, {11'd0, ed, ee, ei});
    endtask

    initial begin
        rst          = 1'b1;
        in_live      = 1'b0;
        in_int_req   = '0;
        in_ext_req   = '0;
        in_delta_req = 1'b0;
        in_lv1b_done = 1'b0;
        int_mask     = 16'h0009;
        ext_mask     = 4'b0100;
        delta_ena    = 1'b1;
        int_prescale = {16{8'd1}};
        int_prescale[31:24] = 8'd4;
        ext_prescale = {4{8'd1}};
        exp_acc      = 0;
        exp_rej      = 0;

        // Reset values
        idle(3);
        check_issue("rst_issue", 16'h0, 4'h0, 1'b0);
        check_eq("rst_busy", 32'(out_busy), 32'd0);
        check_eq("rst_outstanding", 32'(outstanding), 32'd0);
        check_eq("rst_acc", acc_cnt, 32'd0);
        check_eq("rst_rej", rej_cnt, 32'd0);
        check_eq("rst_err", 32'(credit_err), 32'd0);

        // Arm for 8 cycles, then the first request is issued
        rst     = 1'b0;
        in_live = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            busy_cnt += int'(out_busy);
        end
        check_eq("arm_busy_cycles", 32'(busy_cnt), 32'd8);
        tick();
        check_eq("run_not_busy", 32'(out_busy), 32'd0);
        req(16'h0001, 4'h0, 1'b0, 1'b0);
        exp_acc++;
        check_issue("first_issue", 16'h0001, 4'h0, 1'b0);
        check_eq("first_acc", acc_cnt, 32'(exp_acc));
        check_eq("first_busy", 32'(out_busy), 32'd1);
        idle(24);

        // Prescale 4 on source 3: every 4th request passes
        for (int k = 0; k < 12; k++) begin
            req(16'h0008, 4'h0, 1'b0, 1'b0);
            exp_out = ((k % 4) == 3) ? 8 : 0;
            if (exp_out != 0) exp_acc++;
            check_issue($sformatf("psc_req%0d", k), 16'(exp_out), 4'h0, 1'b0);
            idle(24);
        end
        check_eq("psc_acc", acc_cnt, 32'(exp_acc));
        check_eq("psc_rej", rej_cnt, 32'd0);
        check_eq("psc_outstanding", 32'(outstanding), 32'd4);

        // Hold-off: second request 10 cycles later is refused, 20 cycles later accepted
        req(16'h0001, 4'h0, 1'b0, 1'b0);
        exp_acc++;
        check_issue("ho_first", 16'h0001, 4'h0, 1'b0);
        busy_cnt = int'(out_busy);
        for (int i = 1; i < 20; i++) begin
            if (i == 10) begin
                req(16'h0001, 4'h0, 1'b0, 1'b0);
                exp_rej++;
                check_issue("ho_refused", 16'h0, 4'h0, 1'b0);
            end else begin
                tick();
            end
            busy_cnt += int'(out_busy);
        end
        check_eq("ho_busy_cycles", 32'(busy_cnt), 32'd19);
        check_eq("ho_rej", rej_cnt, 32'(exp_rej));
        req(16'h0001, 4'h0, 1'b0, 1'b0);
        exp_acc++;
        check_issue("ho_at_20", 16'h0001, 4'h0, 1'b0);
        idle(19);

        // Simultaneous int 0, ext 2 and delta: one accept
        req(16'h0001, 4'h4, 1'b1, 1'b0);
        exp_acc++;
        check_issue("multi_issue", 16'h0001, 4'h4, 1'b1);
        check_eq("multi_acc", acc_cnt, 32'(exp_acc));
        check_eq("multi_rej", rej_cnt, 32'(exp_rej));
        check_eq("multi_outstanding", 32'(outstanding), 32'd7);
        idle(19);

        // Credit limit: return all credits, then fill all 16
        for (int i = 0; i < 7; i++) req(16'h0, 4'h0, 1'b0, 1'b1);
        check_eq("cr_returned", 32'(outstanding), 32'd0);
        for (int i = 0; i < 16; i++) begin
            req(16'h0001, 4'h0, 1'b0, 1'b0);
            exp_acc++;
            idle(19);
        end
        check_eq("cr_full", 32'(outstanding), 32'd16);
        check_eq("cr_full_busy", 32'(out_busy), 32'd1);
        check_eq("cr_full_acc", acc_cnt, 32'(exp_acc));
        req(16'h0001, 4'h0, 1'b0, 1'b0);
        exp_rej++;
        check_issue("cr_refused", 16'h0, 4'h0, 1'b0);
        check_eq("cr_rej", rej_cnt, 32'(exp_rej));
        req(16'h0001, 4'h0, 1'b0, 1'b1);
        exp_acc++;
        check_issue("cr_done_accept", 16'h0001, 4'h0, 1'b0);
        check_eq("cr_done_outstanding", 32'(outstanding), 32'd16);
        check_eq("cr_done_acc", acc_cnt, 32'(exp_acc));

        // Drain with 3 outstanding
        for (int i = 0; i < 13; i++) req(16'h0, 4'h0, 1'b0, 1'b1);
        check_eq("dr_pre", 32'(outstanding), 32'd3);
        in_live = 1'b0;
        tick();
        req(16'h0001, 4'h4, 1'b1, 1'b0);
        check_issue("dr_no_issue", 16'h0, 4'h0, 1'b0);
        check_eq("dr_acc", acc_cnt, 32'(exp_acc));
        check_eq("dr_rej", rej_cnt, 32'(exp_rej));
        check_eq("dr_busy", 32'(out_busy), 32'd1);
        for (int i = 0; i < 3; i++) req(16'h0, 4'h0, 1'b0, 1'b1);
        check_eq("dr_empty", 32'(outstanding), 32'd0);
        check_eq("dr_no_err", 32'(credit_err), 32'd0);
        tick();
        req(16'h0, 4'h0, 1'b0, 1'b1);
        check_eq("dr_extra_err", 32'(credit_err), 32'd1);
        check_eq("dr_extra_outstanding", 32'(outstanding), 32'd0);
        check_eq("idle_acc_held", acc_cnt, 32'(exp_acc));

        // Re-arm clears statistics and the error flag
        in_live = 1'b1;
        tick();
        check_eq("rearm_acc", acc_cnt, 32'd0);
        check_eq("rearm_rej", rej_cnt, 32'd0);
        check_eq("rearm_err", 32'(credit_err), 32'd0);
        check_eq("rearm_busy", 32'(out_busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
